// File: rtl/run_pkg.sv
// Shared encodings for the run-length detector: FSM states and mode bit indices.
package run_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COUNT   = 2'b01,
    DETECT  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam int MODE_ZERO = 0;
  localparam int MODE_ONE  = 1;

endpackage

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter. clr and inc together restart the count at 1, which is
// how a new run of length one is loaded.
module sat_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= inc ? WIDTH'(1) : '0;
    end else if (inc && (r_q != MAX)) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/run_detector.sv
// Run-length detector: flags runs of RUN_LEN identical qualified samples of w,
// per-polarity enabled by mode, with a saturating detection-event counter.
module run_detector
  import run_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int EVT_W   = 8,
  parameter int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             Resetn,
  input  logic             en,
  input  logic             w,
  input  logic             clr,
  input  logic [1:0]       mode,
  output logic             z,
  output logic             z_pulse,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_cnt,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             sticky,
  output logic [1:0]       state
);

  state_t           r_state;
  logic             r_run_bit;
  logic             r_z_pulse;
  logic             r_sticky;

  logic [CNT_W-1:0] w_run_cnt;
  logic [EVT_W-1:0] w_evt_cnt;
  logic             w_sample;
  logic             w_same;
  logic             w_pol_en;
  logic             w_enter_det;
  logic             w_evt_inc;
  logic             w_run_inc;
  logic             w_run_clr;

  assign w_sample    = en & ~clr;
  assign w_same      = (w == r_run_bit);
  assign w_pol_en    = r_run_bit ? mode[MODE_ONE] : mode[MODE_ZERO];
  assign w_enter_det = w_sample && (r_state == COUNT) && w_same &&
                       (w_run_cnt == CNT_W'(RUN_LEN - 1));
  // The entered polarity equals r_run_bit because w matched it.
  assign w_evt_inc   = w_enter_det & w_pol_en;

  always_comb begin
    w_run_inc = 1'b0;
    w_run_clr = 1'b0;
    if (clr || (r_state == ILLEGAL)) begin
      w_run_clr = 1'b1;
    end else if (en) begin
      w_run_inc = 1'b1;
      if ((r_state == IDLE) || !w_same) begin
        w_run_clr = 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (CNT_W'(RUN_LEN))
  ) u_run_cnt (
    .clk   (clk),
    .rst_n (Resetn),
    .inc   (w_run_inc),
    .clr   (w_run_clr),
    .q     (w_run_cnt)
  );

  sat_counter #(
    .WIDTH (EVT_W),
    .MAX   ({EVT_W{1'b1}})
  ) u_evt_cnt (
    .clk   (clk),
    .rst_n (Resetn),
    .inc   (w_evt_inc),
    .clr   (clr),
    .q     (w_evt_cnt)
  );

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= IDLE;
      r_run_bit <= 1'b0;
      r_z_pulse <= 1'b0;
      r_sticky  <= 1'b0;
    end else if (clr) begin
      r_state   <= IDLE;
      r_run_bit <= 1'b0;
      r_z_pulse <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_z_pulse <= w_evt_inc;
      if (w_evt_inc) begin
        r_sticky <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (en) begin
            r_run_bit <= w;
            r_state   <= COUNT;
          end
        end
        COUNT: begin
          if (en) begin
            if (!w_same) begin
              r_run_bit <= w;
            end else if (w_enter_det) begin
              r_state <= DETECT;
            end
          end
        end
        DETECT: begin
          if (en && !w_same) begin
            r_run_bit <= w;
            r_state   <= COUNT;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_run_bit <= 1'b0;
        end
      endcase
    end
  end

  assign z       = (r_state == DETECT) & w_pol_en;
  assign z_pulse = r_z_pulse;
  assign run_bit = r_run_bit;
  assign run_cnt = w_run_cnt;
  assign evt_cnt = w_evt_cnt;
  assign sticky  = r_sticky;
  assign state   = r_state;

endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
- Parametrised run-length detector for a serial bit stream, sampled on a qualified clock edge.
- Asserts a level output while the current run of identical bits is at least RUN_LEN long, and a one-cycle pulse at each new detection.
- Each polarity (0-runs, 1-runs) is enabled per mode bit. A saturating detection-event counter is provided.
- Successor to the fixed four-in-a-row detector used on the board-level lab tops; drives LED/status logic or downstream control.

Parameters:
- RUN_LEN, 4, number of consecutive identical bits required for detection; legal range >= 2.
- EVT_W, 8, width of the detection-event counter.
- CNT_W, $clog2(RUN_LEN+1), width of the run-length counter. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- Resetn  input  1  asynchronous active-low reset.
- en  input  1  sample qualifier; w is consumed only on edges where en=1.
- w  input  1  serial data bit.
- clr  input  1  synchronous clear of run state, sticky flag and event counter.
- mode  input  2  bit0 enables detection of 0-runs; bit1 enables detection of 1-runs.
- z  output  1  level: current run qualifies and its polarity is enabled.
- z_pulse  output  1  one-cycle pulse on each new enabled detection.
- run_bit  output  1  value of the bit forming the current run.
- run_cnt  output  CNT_W  current run length, saturating at RUN_LEN.
- evt_cnt  output  EVT_W  number of enabled detections since reset/clr, saturating at all-ones.
- sticky  output  1  set on any enabled detection; held until clr or reset.
- state  output  2  FSM state, for debug/LED display.

Behaviour:
- Reset (Resetn=0, asynchronous): state=IDLE, run_cnt=0, run_bit=0, z=0, z_pulse=0, evt_cnt=0, sticky=0.
- FSM states: IDLE=2'b00 (no sample since reset/clr), COUNT=2'b01 (run shorter than RUN_LEN), DETECT=2'b10. Encoding 2'b11 is illegal and recovers to IDLE on the next edge.
- Edges with en=1 and clr=0:
  - IDLE: run_bit<=w, run_cnt<=1, go to COUNT.
  - COUNT, w==run_bit: run_cnt<=run_cnt+1. If the new value equals RUN_LEN, go to DETECT.
  - COUNT, w!=run_bit: run_bit<=w, run_cnt<=1, stay in COUNT.
  - DETECT, w==run_bit: stay in DETECT; run_cnt holds at RUN_LEN.
  - DETECT, w!=run_bit: run_bit<=w, run_cnt<=1, go to COUNT. This matches the predecessor's F/B behaviour: the opposite bit starts a new run of length 1.
- Edges with en=0: all state, counters and flags hold; z_pulse<=0.
- clr=1: takes priority over en. Same values as reset, applied synchronously.
- Latency: z rises in the cycle following the edge that samples the RUN_LEN-th identical bit, and falls in the cycle following the edge that samples a differing bit.
- z is combinational from registered state: (state==DETECT) & mode[run_bit]. A mode change mid-run affects z immediately but never generates z_pulse.
- On the COUNT->DETECT transition edge, if mode[run_bit] (the value being entered) is 1:
  - z_pulse<=1 for exactly one cycle.
  - evt_cnt<=evt_cnt+1, saturating at 2^EVT_W-1.
  - sticky<=1.
- Transitions into DETECT with the polarity disabled produce no pulse, count or sticky.
- Back-to-back runs: a run of opposite polarity reaches DETECT RUN_LEN samples after the switch, giving a fresh pulse and count.
- Counter widths: run_cnt never exceeds RUN_LEN. evt_cnt never wraps.

Decomposition:
- Shared package run_pkg holds:
  - the state encoding constants (IDLE/COUNT/DETECT);
  - the mode bit indices MODE_ZERO=0 and MODE_ONE=1.
- One sub-module, sat_counter (WIDTH, MAX; inc, clr, q). It is instantiated for both run_cnt (MAX=RUN_LEN) and evt_cnt (MAX=2^EVT_W-1).
- FSM and output logic live in run_detector.

Test Plan:
- Reset, mode=2'b01, en=1, w=0,0,0,0,0 -> z=1 after the 4th edge, z_pulse=1 for that one cycle only, evt_cnt=1, run_cnt=4 held through the 5th sample.
- mode=2'b11, w=1,1,1,1 then 0,0,0,0 -> two z_pulses 4 cycles apart, evt_cnt=2; z=0 for exactly the 3 cycles following the first 0 sample (during 0-samples 1–3), then z=1 again.
- mode=2'b10, w=0 x6 -> state=DETECT but z=0, z_pulse never asserted, evt_cnt=0, sticky=0. Then set mode=2'b11 -> z=1 same cycle, no pulse.
- w=1,1,1 with en=0 for 5 cycles, then en=1, w=1 -> detection on the 4th qualified sample; nothing changes while en=0.
- In DETECT with evt_cnt=5, assert clr together with en=1, w=1 -> next cycle state=IDLE, run_cnt=0, evt_cnt=0, sticky=0, z=0. Also deassert Resetn mid-run -> outputs clear without a clock edge.
- EVT_W=2, RUN_LEN=2, mode=2'b11, alternate w pairs 00 11 00 11 00 -> evt_cnt saturates at 3 and stays 3; z_pulse still fires on each detection.
